// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load and wrap/saturate mode.
// Flags: tc (combinational terminal count), wrap (one-cycle pulse), sat (held at limit).
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
      sat_d   = 1'b0;
    end else if (enable) begin
      if (dir) begin
        if (!at_max) begin
          count_d = count_q + WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          sat_d = 1'b1;
        end else begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = SATURATE ? sat_q : 1'b0;
  assign tc    = enable & ((dir & at_max) | (~dir & at_zero));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three builds (mod-16 wrap, mod-10 wrap, mod-16 saturate) on shared stimulus,
// checked every cycle against an arithmetic model plus hand-computed literal expectations.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, enable, dir, load;
  logic [3:0] load_value;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       sat_a, sat_b, sat_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load), .load_value(load_value),
    .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));

  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load), .load_value(load_value),
    .count(cnt_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b));

  updown_mod_counter #(.WIDTH(4), .SATURATE(1'b1)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load), .load_value(load_value),
    .count(cnt_c), .tc(tc_c), .wrap(wrap_c), .sat(sat_c));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count range 0..lim, wrapping or holding at the ends.
  int  m_count [3];
  int  m_wrap  [3];
  int  m_sat   [3];
  int  m_lim   [3] = '{15, 9, 15};
  bit  m_satm  [3] = '{1'b0, 1'b0, 1'b1};
  bit  model_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_count[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
      end else if (load) begin
        m_count[i] = (int'(load_value) > m_lim[i]) ? m_lim[i] : int'(load_value);
        m_wrap[i] = 0; m_sat[i] = 0;
      end else if (enable) begin
        int nxt;
        nxt = dir ? m_count[i] + 1 : m_count[i] - 1;
        m_wrap[i] = 0;
        if (nxt >= 0 && nxt <= m_lim[i]) begin
          m_count[i] = nxt; m_sat[i] = 0;
        end else if (m_satm[i]) begin
          m_sat[i] = 1;
        end else begin
          m_count[i] = dir ? 0 : m_lim[i];
          m_wrap[i] = 1;
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
    if (reset) model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      int ac [3];
      int at [3];
      int aw [3];
      int as [3];
      ac = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
      at = '{int'(tc_a), int'(tc_b), int'(tc_c)};
      aw = '{int'(wrap_a), int'(wrap_b), int'(wrap_c)};
      as = '{int'(sat_a), int'(sat_b), int'(sat_c)};
      for (int i = 0; i < 3; i++) begin
        int etc;
        etc = (enable && ((dir && m_count[i] == m_lim[i]) || (!dir && m_count[i] == 0))) ? 1 : 0;
        chk($sformatf("model_count[%0d]", i), ac[i], m_count[i]);
        chk($sformatf("model_tc[%0d]", i), at[i], etc);
        chk($sformatf("model_wrap[%0d]", i), aw[i], m_wrap[i]);
        chk($sformatf("model_sat[%0d]", i), as[i], m_sat[i]);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [3:0] lv);
    reset = r; enable = e; dir = d; load = l; load_value = lv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk("reset_count_a", int'(cnt_a), 0);
    chk("reset_wrap_a", int'(wrap_a), 0);
    chk("reset_sat_c", int'(sat_c), 0);
    chk("reset_tc_a_disabled", int'(tc_a), 0);

    // Down-count wrap
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("release_tc_a", int'(tc_a), 1);
    tick();
    chk("down_wrap_count_a", int'(cnt_a), 15);
    chk("down_wrap_flag_a", int'(wrap_a), 1);
    chk("down_wrap_count_b", int'(cnt_b), 9);
    chk("down_sat_count_c", int'(cnt_c), 0);
    chk("down_sat_flag_c", int'(sat_c), 1);
    chk("down_sat_nowrap_c", int'(wrap_c), 0);
    repeat (15) tick();
    chk("down_zero_count_a", int'(cnt_a), 0);
    chk("down_zero_tc_a", int'(tc_a), 1);
    chk("down_zero_wrap_a", int'(wrap_a), 0);
    tick();
    chk("down_rewrap_count_a", int'(cnt_a), 15);
    chk("down_rewrap_flag_a", int'(wrap_a), 1);
    repeat (6) tick();
    chk("mid_count_a", int'(cnt_a), 9);

    // Enable gating
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    chk("gate_count_a", int'(cnt_a), 9);
    chk("gate_wrap_a", int'(wrap_a), 0);
    chk("gate_tc_a", int'(tc_a), 0);

    // Non-power-of-two modulus, up then down from zero
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (9) tick();
    chk("mod10_top_b", int'(cnt_b), 9);
    chk("mod10_tc_b", int'(tc_b), 1);
    tick();
    chk("mod10_wrap_count_b", int'(cnt_b), 0);
    chk("mod10_wrap_flag_b", int'(wrap_b), 1);
    chk("mod10_up_a", int'(cnt_a), 10);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk("mod10_down_from0_b", int'(cnt_b), 9);
    chk("mod10_down_wrap_b", int'(wrap_b), 1);

    // Saturate mode from 14 (load wins over enable)
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd14);
    tick();
    chk("sat_load_c", int'(cnt_c), 14);
    chk("sat_load_clamp_b", int'(cnt_b), 9);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk("sat_first15_c", int'(cnt_c), 15);
    chk("sat_first15_flag_c", int'(sat_c), 0);
    tick();
    chk("sat_second15_c", int'(cnt_c), 15);
    chk("sat_second15_flag_c", int'(sat_c), 1);
    chk("sat_nowrap_c", int'(wrap_c), 0);
    tick();
    chk("sat_hold_flag_c", int'(sat_c), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    chk("sat_release_count_c", int'(cnt_c), 14);
    chk("sat_release_flag_c", int'(sat_c), 0);

    // Load priority and clamp
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    tick();
    chk("clamp_count_b", int'(cnt_b), 9);
    chk("clamp_noclamp_a", int'(cnt_a), 12);
    chk("clamp_nowrap_b", int'(wrap_b), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk("clamp_step_count_b", int'(cnt_b), 0);
    chk("clamp_step_wrap_b", int'(wrap_b), 1);
    chk("clamp_step_a", int'(cnt_a), 13);

    // Reset mid-operation beats load and enable
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
    tick();
    chk("pre_reset_a", int'(cnt_a), 7);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    chk("midreset_count_a", int'(cnt_a), 0);
    chk("midreset_wrap_a", int'(wrap_a), 0);
    chk("midreset_sat_c", int'(sat_c), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk("resume_count_a", int'(cnt_a), 1);
    repeat (3) tick();
    chk("resume_more_a", int'(cnt_a), 4);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
